sqrt_seq_ctrl: RTL and testbench
================================

Name: sqrt_seq_ctrl

Overview:
- Multi-cycle sequencer for the square-root stage of the Box-Muller AWGN datapath.
- Accepts one operand from the log stage and counts its leading zeros serially.
- Drives the range-reduction block (exp_f / LZD_Sqrt / y_f in, f_temp out) and fetches polynomial coefficients from the coefficient ROM.
- Arbitrates for the shared multiplier via req/gnt, evaluates c1*f + c0 and returns the result with a valid/ready handshake.

Parameters:
- X_W, 31, operand width.
- F_W, 21, mantissa/result width; also the multiplier operand width.
- COEF_AW, 6, coefficient ROM address width, taken from the top COEF_AW bits of f_temp.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  high only in IDLE.
- in_x  in  X_W  operand, sampled on in_valid&in_ready.
- rr_exp_f  out  6  to range block exp_f.
- rr_lzd  out  6  to range block LZD_Sqrt.
- rr_y_f  out  F_W  to range block y_f.
- rr_f_temp  in  F_W  from range block; combinational.
- coef_addr  out  COEF_AW  ROM address.
- coef_c1  in  F_W  ROM slope; combinational.
- coef_c0  in  F_W  ROM intercept; combinational.
- mul_req  out  1  shared-multiplier request.
- mul_gnt  in  1  grant.
- mul_a  out  F_W  multiplier operand A.
- mul_b  out  F_W  multiplier operand B.
- mul_ack  in  1  product valid, one-cycle pulse.
- mul_p  in  2*F_W  product.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer ready.
- out_f  out  F_W  sqrt mantissa.
- out_exp  out  6  result exponent (rr_exp_f >> 1).
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values: in_ready=1, mul_req=0, out_valid=0, busy=0. All data registers (out_f, out_exp, rr_*, mul_a, mul_b, coef_addr, lzd, x_reg) reset to 0. State resets to IDLE.
- Reset assertion mid-operation aborts immediately: any pending mul_req drops asynchronously; a late mul_ack after reset is ignored.
- IDLE: on in_valid&in_ready, x_reg<=in_x, lzd<=0, go to SCAN.
- SCAN (one bit per cycle):
  - x_reg[X_W-1]=1: go to RANGE.
  - Otherwise x_reg<=x_reg<<1 and lzd<=lzd+1.
  - If lzd reaches X_W (operand zero): go to ZERO.
- Range-block outputs are registered on entry to RANGE:
  - rr_lzd=lzd.
  - rr_exp_f=(6'd31-lzd) mod 64.
  - rr_y_f=x_reg[X_W-1 -: F_W] (normalized top bits).
- RANGE (1 cycle):
  - f_reg<=rr_f_temp.
  - coef_addr<=rr_f_temp[F_W-1 -: COEF_AW].
  - Go to REQ.
- REQ:
  - mul_req=1; mul_a=coef_c1 and mul_b=f_reg, held stable until grant.
  - c0_reg captured.
  - On mul_gnt=1: go to WAIT; mul_req drops the next cycle.
  - mul_gnt while mul_req=0 is ignored.
- WAIT:
  - Hold until mul_ack; mul_ack arrives earliest the cycle after grant.
  - p_reg<=mul_p, go to ACC.
- ACC (1 cycle):
  - sum=(p_reg>>(F_W-1))+c0_reg, computed at F_W+1 bits.
  - Saturate to all ones on overflow.
  - out_f<=sum; out_exp<=rr_exp_f>>1.
  - Go to OUT.
- ZERO (1 cycle): out_f<=0, out_exp<=0, go to OUT. No multiplier request is made.
- OUT:
  - out_valid=1; out_f and out_exp are held stable until out_ready.
  - out_valid&out_ready returns to IDLE; in_ready rises the following cycle (no same-cycle accept).
- Latency from accept to out_valid is 6+lzd cycles when grant and ack are immediate. Each cycle gnt is withheld adds 1; each extra ack delay cycle adds 1.
- Zero operand: out_valid exactly 33 cycles after accept.

Optional Feature:
- Macro: SQRT_SEQ_CTRL_PERF_EN.
- When defined, two outputs are added:
  - perf_ops[15:0]: increments on each out_valid&out_ready.
  - perf_stall[15:0]: increments each cycle in REQ with mul_gnt=0.
- Both counters saturate at 16'hFFFF and reset to 0 on rst_n.
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- in_x=31'h4000_0000, gnt same cycle as req, ack next cycle, out_ready=1 -> rr_lzd=0, rr_exp_f=31, out_valid 6 cycles after accept, out_exp=15.
- in_x=31'h0000_0400 -> rr_lzd=20, rr_exp_f=11, rr_y_f=21'h100000, out_valid 26 cycles after accept.
- in_x=0 -> no mul_req ever asserted, out_f=0, out_exp=0, out_valid 33 cycles after accept.
- mul_gnt withheld 5 cycles -> mul_a/mul_b stable throughout REQ, latency +5, perf_stall=5 with macro defined.
- coef_c1=21'h1FFFFF, f=21'h1FFFFF, coef_c0=21'h1FFFFF -> out_f saturates to 21'h1FFFFF. out_ready low for 4 cycles -> out_valid/out_f held, in_ready=0 throughout.
- rst_n pulsed low while in WAIT -> mul_req=0, out_valid=0, in_ready=1 asynchronously; a mul_ack arriving after reset release produces no output.

Source files
------------

// File: rtl/sqrt_seq_ctrl.sv
// Square-root stage sequencer for the Box-Muller AWGN datapath: serial leading-zero scan,
// range reduction, coefficient fetch, shared-multiplier c1*f + c0. Optional counters: SQRT_SEQ_CTRL_PERF_EN.
module sqrt_seq_ctrl #(
    parameter int X_W     = 31,
    parameter int F_W     = 21,
    parameter int COEF_AW = 6
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef SQRT_SEQ_CTRL_PERF_EN
    output logic [15:0]        perf_ops,
    output logic [15:0]        perf_stall,
`endif
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [X_W-1:0]     in_x,
    output logic [5:0]         rr_exp_f,
    output logic [5:0]         rr_lzd,
    output logic [F_W-1:0]     rr_y_f,
    input  logic [F_W-1:0]     rr_f_temp,
    output logic [COEF_AW-1:0] coef_addr,
    input  logic [F_W-1:0]     coef_c1,
    input  logic [F_W-1:0]     coef_c0,
    output logic               mul_req,
    input  logic               mul_gnt,
    output logic [F_W-1:0]     mul_a,
    output logic [F_W-1:0]     mul_b,
    input  logic               mul_ack,
    input  logic [2*F_W-1:0]   mul_p,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [F_W-1:0]     out_f,
    output logic [5:0]         out_exp,
    output logic               busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_SCAN, S_RANGE, S_REQ, S_WAIT, S_ACC, S_ZERO, S_OUT
    } state_t;

    localparam logic [5:0] LZD_LAST = 6'(X_W - 1);

    state_t           state;
    logic [X_W-1:0]   x_reg;
    logic [5:0]       lzd;
    logic [F_W-1:0]   f_reg;
    logic [F_W-1:0]   c0_reg;
    logic [F_W:0]     p_hi;
    logic [F_W+1:0]   acc_sum;
    logic [F_W-1:0]   acc_sat;
    logic             unused_p_lsb;

    // Product is Q2.(2F-2); only the bits at and above the binary point of f feed the sum.
    assign unused_p_lsb = &{1'b0, mul_p[F_W-2:0]};
    assign acc_sum      = {1'b0, p_hi} + {2'b00, c0_reg};
    assign acc_sat      = (acc_sum[F_W+1:F_W] != 2'b00) ? {F_W{1'b1}} : acc_sum[F_W-1:0];

    // NOTE: operands come straight from the combinational ROM so they are valid in the
    // very first REQ cycle; gating to zero outside REQ keeps them quiet on the shared bus.
    assign mul_a = (state == S_REQ) ? coef_c1 : '0;
    assign mul_b = (state == S_REQ) ? f_reg   : '0;

    // NOTE: every register here is plain flop state (no memories), so all of it is cleared
    // by reset; non-blocking assignments keep next-state reads using the old values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            mul_req   <= 1'b0;
            out_valid <= 1'b0;
            x_reg     <= '0;
            lzd       <= '0;
            rr_lzd    <= '0;
            rr_exp_f  <= '0;
            rr_y_f    <= '0;
            f_reg     <= '0;
            coef_addr <= '0;
            c0_reg    <= '0;
            p_hi      <= '0;
            out_f     <= '0;
            out_exp   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        x_reg    <= in_x;
                        lzd      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (x_reg[X_W-1]) begin
                        rr_lzd   <= lzd;
                        rr_exp_f <= 6'd31 - lzd;
                        rr_y_f   <= x_reg[X_W-1 -: F_W];
                        state    <= S_RANGE;
                    end else begin
                        x_reg <= x_reg << 1;
                        lzd   <= lzd + 6'd1;
                        // The last shift of an all-zero operand ends the scan.
                        if (lzd == LZD_LAST) state <= S_ZERO;
                    end
                end
                S_RANGE: begin
                    f_reg     <= rr_f_temp;
                    coef_addr <= rr_f_temp[F_W-1 -: COEF_AW];
                    mul_req   <= 1'b1;
                    state     <= S_REQ;
                end
                S_REQ: begin
                    c0_reg <= coef_c0;
                    if (mul_gnt) begin
                        mul_req <= 1'b0;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mul_ack) begin
                        p_hi  <= mul_p[2*F_W-1 -: F_W+1];
                        state <= S_ACC;
                    end
                end
                S_ACC: begin
                    out_f     <= acc_sat;
                    out_exp   <= rr_exp_f >> 1;
                    out_valid <= 1'b1;
                    state     <= S_OUT;
                end
                S_ZERO: begin
                    out_f     <= '0;
                    out_exp   <= '0;
                    out_valid <= 1'b1;
                    state     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SQRT_SEQ_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_ops   <= '0;
            perf_stall <= '0;
        end else begin
            if (out_valid && out_ready && perf_ops != 16'hFFFF)
                perf_ops <= perf_ops + 16'd1;
            if (state == S_REQ && !mul_gnt && perf_stall != 16'hFFFF)
                perf_stall <= perf_stall + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sqrt_seq_ctrl.sv
// Directed self-checking bench for sqrt_seq_ctrl; drives the range block, coefficient ROM
// and shared multiplier from the bench, with hand-computed expected results.
module tb_sqrt_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [30:0] in_x;
    wire         in_ready;
    wire  [5:0]  rr_exp_f;
    wire  [5:0]  rr_lzd;
    wire  [20:0] rr_y_f;
    logic [20:0] rr_f_temp;
    wire  [5:0]  coef_addr;
    logic [20:0] coef_c1;
    logic [20:0] coef_c0;
    wire         mul_req;
    logic        mul_gnt;
    wire  [20:0] mul_a;
    wire  [20:0] mul_b;
    logic        mul_ack;
    logic [41:0] mul_p;
    wire         out_valid;
    logic        out_ready;
    wire  [20:0] out_f;
    wire  [5:0]  out_exp;
    wire         busy;
`ifdef SQRT_SEQ_CTRL_PERF_EN
    wire  [15:0] perf_ops;
    wire  [15:0] perf_stall;
`endif

    sqrt_seq_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef SQRT_SEQ_CTRL_PERF_EN
        .perf_ops   (perf_ops),
        .perf_stall (perf_stall),
`endif
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .rr_exp_f   (rr_exp_f),
        .rr_lzd     (rr_lzd),
        .rr_y_f     (rr_y_f),
        .rr_f_temp  (rr_f_temp),
        .coef_addr  (coef_addr),
        .coef_c1    (coef_c1),
        .coef_c0    (coef_c0),
        .mul_req    (mul_req),
        .mul_gnt    (mul_gnt),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_ack    (mul_ack),
        .mul_p      (mul_p),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_f      (out_f),
        .out_exp    (out_exp),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Observations recorded by run_op for the scenario tasks to judge.
    int          lat;
    int          ov_cycles;
    logic        timed_out;
    logic        req_seen;
    logic        ab_changed;
    logic        hold_bad;
    logic        rdy_after;
    logic        start_not_ready;
    logic [20:0] a_obs;
    logic [20:0] b_obs;
    logic [20:0] f_obs;
    logic [5:0]  e_obs;

    // One transaction, stepped on negedges: inputs change mid-cycle, outputs sampled mid-cycle.
    task automatic run_op(input logic [30:0] x, input int gnt_wait, input int ack_wait,
                          input int rdy_wait);
        int          cyc;
        int          req_cyc;
        int          ack_cnt;
        logic        ack_armed;
        logic        done;
        logic [41:0] prod;
        lat = -1; ov_cycles = 0; timed_out = 1'b0; req_seen = 1'b0; ab_changed = 1'b0;
        hold_bad = 1'b0; f_obs = '0; e_obs = '0; a_obs = '0; b_obs = '0;
        cyc = 0; req_cyc = 0; ack_cnt = 0; ack_armed = 1'b0; done = 1'b0; prod = '0;
        start_not_ready = !in_ready;
        in_valid = 1'b1;
        in_x     = x;
        while (!done && cyc < 300) begin
            @(negedge clk);
            cyc++;
            in_valid  = 1'b0;
            mul_gnt   = 1'b0;
            mul_ack   = 1'b0;
            out_ready = 1'b0;
            if (ack_armed) begin
                if (ack_cnt == 0) begin
                    mul_ack   = 1'b1;
                    mul_p     = prod;
                    ack_armed = 1'b0;
                end else begin
                    ack_cnt--;
                end
            end
            if (mul_req) begin
                if (!req_seen) begin
                    a_obs    = mul_a;
                    b_obs    = mul_b;
                    req_seen = 1'b1;
                end else if (mul_a !== a_obs || mul_b !== b_obs) begin
                    ab_changed = 1'b1;
                end
                if (req_cyc >= gnt_wait) begin
                    mul_gnt   = 1'b1;
                    prod      = mul_a * mul_b;
                    ack_armed = 1'b1;
                    ack_cnt   = ack_wait;
                end
                req_cyc++;
            end
            if (out_valid) begin
                if (lat < 0) begin
                    lat   = cyc;
                    f_obs = out_f;
                    e_obs = out_exp;
                end else if (out_f !== f_obs || out_exp !== e_obs) begin
                    hold_bad = 1'b1;
                end
                if (in_ready) hold_bad = 1'b1;
                ov_cycles++;
                if (ov_cycles > rdy_wait) begin
                    out_ready = 1'b1;
                    done      = 1'b1;
                end
            end
        end
        timed_out = !done;
        @(negedge clk);
        rdy_after = in_ready;
        out_ready = 1'b0;
        mul_gnt   = 1'b0;
        mul_ack   = 1'b0;
    endtask

    task automatic test_reset;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_checks++; if (mul_req !== 1'b0) begin n_fail++; $display("FAIL reset_mul_req got=%b exp=0", mul_req); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if ({out_f, out_exp} !== 27'h0) begin n_fail++; $display("FAIL reset_out_data got=%h/%h exp=0/0", out_f, out_exp); end
        n_checks++; if ({rr_exp_f, rr_lzd, rr_y_f, coef_addr} !== 39'h0) begin n_fail++; $display("FAIL reset_rr_data got=%h %h %h %h exp=0", rr_exp_f, rr_lzd, rr_y_f, coef_addr); end
        n_checks++; if ({mul_a, mul_b} !== 42'h0) begin n_fail++; $display("FAIL reset_mul_ops got=%h/%h exp=0/0", mul_a, mul_b); end
    endtask

    task automatic test_basic;
        rr_f_temp = 21'h123456; coef_c1 = 21'h100000; coef_c0 = 21'h001000;
        run_op(31'h4000_0000, 0, 0, 0);
        n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL basic_timeout got=%b exp=0", timed_out); end
        n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL basic_latency got=%0d exp=6", lat); end
        n_checks++; if (rr_lzd !== 6'd0) begin n_fail++; $display("FAIL basic_rr_lzd got=%0d exp=0", rr_lzd); end
        n_checks++; if (rr_exp_f !== 6'd31) begin n_fail++; $display("FAIL basic_rr_exp_f got=%0d exp=31", rr_exp_f); end
        n_checks++; if (rr_y_f !== 21'h100000) begin n_fail++; $display("FAIL basic_rr_y_f got=%h exp=100000", rr_y_f); end
        n_checks++; if (coef_addr !== 6'h24) begin n_fail++; $display("FAIL basic_coef_addr got=%h exp=24", coef_addr); end
        n_checks++; if (a_obs !== 21'h100000 || b_obs !== 21'h123456) begin n_fail++; $display("FAIL basic_mul_ops got=%h/%h exp=100000/123456", a_obs, b_obs); end
        n_checks++; if (f_obs !== 21'h124456) begin n_fail++; $display("FAIL basic_out_f got=%h exp=124456", f_obs); end
        n_checks++; if (e_obs !== 6'd15) begin n_fail++; $display("FAIL basic_out_exp got=%0d exp=15", e_obs); end
        n_checks++; if (rdy_after !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready_after got=%b exp=1", rdy_after); end
    endtask

    task automatic test_lzd20;
        rr_f_temp = 21'h0F0000; coef_c1 = 21'h080000; coef_c0 = 21'h000123;
        run_op(31'h0000_0400, 0, 0, 0);
        n_checks++; if (lat !== 26) begin n_fail++; $display("FAIL lzd20_latency got=%0d exp=26", lat); end
        n_checks++; if (rr_lzd !== 6'd20) begin n_fail++; $display("FAIL lzd20_rr_lzd got=%0d exp=20", rr_lzd); end
        n_checks++; if (rr_exp_f !== 6'd11) begin n_fail++; $display("FAIL lzd20_rr_exp_f got=%0d exp=11", rr_exp_f); end
        n_checks++; if (rr_y_f !== 21'h100000) begin n_fail++; $display("FAIL lzd20_rr_y_f got=%h exp=100000", rr_y_f); end
        n_checks++; if (coef_addr !== 6'h1E) begin n_fail++; $display("FAIL lzd20_coef_addr got=%h exp=1e", coef_addr); end
        n_checks++; if (f_obs !== 21'h078123) begin n_fail++; $display("FAIL lzd20_out_f got=%h exp=078123", f_obs); end
        n_checks++; if (e_obs !== 6'd5) begin n_fail++; $display("FAIL lzd20_out_exp got=%0d exp=5", e_obs); end
    endtask

    task automatic test_zero;
        coef_c0 = 21'h00ABCD;
        run_op(31'h0, 0, 0, 0);
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL zero_latency got=%0d exp=33", lat); end
        n_checks++; if (req_seen !== 1'b0) begin n_fail++; $display("FAIL zero_no_mul_req got=%b exp=0", req_seen); end
        n_checks++; if (f_obs !== 21'h0 || e_obs !== 6'd0) begin n_fail++; $display("FAIL zero_out got=%h/%0d exp=0/0", f_obs, e_obs); end
        n_checks++; if (rdy_after !== 1'b1) begin n_fail++; $display("FAIL zero_in_ready_after got=%b exp=1", rdy_after); end
    endtask

    task automatic test_gnt_stall;
        rr_f_temp = 21'h123456; coef_c1 = 21'h100000; coef_c0 = 21'h001000;
        run_op(31'h4000_0000, 5, 0, 0);
        n_checks++; if (lat !== 11) begin n_fail++; $display("FAIL stall_latency got=%0d exp=11", lat); end
        n_checks++; if (ab_changed !== 1'b0) begin n_fail++; $display("FAIL stall_ops_stable got=%b exp=0", ab_changed); end
        n_checks++; if (a_obs !== 21'h100000 || b_obs !== 21'h123456) begin n_fail++; $display("FAIL stall_mul_ops got=%h/%h exp=100000/123456", a_obs, b_obs); end
        n_checks++; if (f_obs !== 21'h124456) begin n_fail++; $display("FAIL stall_out_f got=%h exp=124456", f_obs); end
`ifdef SQRT_SEQ_CTRL_PERF_EN
        n_checks++; if (perf_stall !== 16'd5) begin n_fail++; $display("FAIL perf_stall got=%0d exp=5", perf_stall); end
        n_checks++; if (perf_ops !== 16'd4) begin n_fail++; $display("FAIL perf_ops got=%0d exp=4", perf_ops); end
`endif
    endtask

    task automatic test_saturate_backpressure;
        rr_f_temp = 21'h1FFFFF; coef_c1 = 21'h1FFFFF; coef_c0 = 21'h1FFFFF;
        run_op(31'h4000_0000, 0, 0, 4);
        n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL sat_latency got=%0d exp=6", lat); end
        n_checks++; if (coef_addr !== 6'h3F) begin n_fail++; $display("FAIL sat_coef_addr got=%h exp=3f", coef_addr); end
        n_checks++; if (f_obs !== 21'h1FFFFF) begin n_fail++; $display("FAIL sat_out_f got=%h exp=1fffff", f_obs); end
        n_checks++; if (ov_cycles !== 5) begin n_fail++; $display("FAIL sat_valid_cycles got=%0d exp=5", ov_cycles); end
        n_checks++; if (hold_bad !== 1'b0) begin n_fail++; $display("FAIL sat_hold got=%b exp=0", hold_bad); end
    endtask

    task automatic test_back_to_back;
        rr_f_temp = 21'h000010; coef_c1 = 21'h100000; coef_c0 = 21'h000000;
        run_op(31'h0000_0001, 0, 2, 0);
        n_checks++; if (lat !== 38) begin n_fail++; $display("FAIL b2b_ack_delay_latency got=%0d exp=38", lat); end
        n_checks++; if (rr_lzd !== 6'd30 || rr_exp_f !== 6'd1) begin n_fail++; $display("FAIL b2b_rr got=%0d/%0d exp=30/1", rr_lzd, rr_exp_f); end
        n_checks++; if (f_obs !== 21'h000010 || e_obs !== 6'd0) begin n_fail++; $display("FAIL b2b_first_out got=%h/%0d exp=000010/0", f_obs, e_obs); end
        rr_f_temp = 21'h123456; coef_c0 = 21'h001000;
        run_op(31'h4000_0000, 0, 0, 0);
        n_checks++; if (start_not_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_at_start got=%b exp=0", start_not_ready); end
        n_checks++; if (lat !== 6 || f_obs !== 21'h124456) begin n_fail++; $display("FAIL b2b_second got=%0d/%h exp=6/124456", lat, f_obs); end
    endtask

    task automatic test_reset_abort;
        logic [41:0] prod;
        logic        late_out;
        rr_f_temp = 21'h123456; coef_c1 = 21'h100000; coef_c0 = 21'h001000;
        // Abort while the request is pending.
        in_valid = 1'b1; in_x = 31'h4000_0000;
        @(negedge clk); in_valid = 1'b0;
        for (int i = 0; i < 20 && !mul_req; i++) @(negedge clk);
        n_checks++; if (mul_req !== 1'b1) begin n_fail++; $display("FAIL abort_req_reached got=%b exp=1", mul_req); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (mul_req !== 1'b0) begin n_fail++; $display("FAIL abort_req_drop got=%b exp=0", mul_req); end
        n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_req_idle got=%b/%b exp=1/0", in_ready, busy); end
        @(negedge clk); rst_n = 1'b1;
        // Abort while waiting for the product, then deliver a stale ack.
        in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        for (int i = 0; i < 20 && !mul_req; i++) @(negedge clk);
        prod    = mul_a * mul_b;
        mul_gnt = 1'b1;
        @(negedge clk); mul_gnt = 1'b0;
        n_checks++; if (busy !== 1'b1 || mul_req !== 1'b0) begin n_fail++; $display("FAIL abort_wait_reached got=%b/%b exp=1/0", busy, mul_req); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || mul_req !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_wait_idle got=%b/%b/%b/%b exp=0/1/0/0", out_valid, in_ready, mul_req, busy);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); mul_ack = 1'b1; mul_p = prod;
        @(negedge clk); mul_ack = 1'b0;
        late_out = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid || !in_ready || busy) late_out = 1'b1;
        end
        n_checks++; if (late_out !== 1'b0) begin n_fail++; $display("FAIL abort_late_ack got=%b exp=0", late_out); end
        n_checks++; if (out_f !== 21'h0) begin n_fail++; $display("FAIL abort_out_f got=%h exp=0", out_f); end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_x = '0; rr_f_temp = '0; coef_c1 = '0; coef_c0 = '0;
        mul_gnt = 1'b0; mul_ack = 1'b0; mul_p = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        test_reset;
        @(negedge clk);
        test_basic;
        test_lzd20;
        test_zero;
        test_gnt_stall;
        test_saturate_backpressure;
        test_back_to_back;
        test_reset_abort;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before the scenarios completed");
        $fatal(1);
    end

endmodule
